// File: rtl/sccb_init_pkg.sv
// Shared types, constants and the register table for the SCCB init engine.
//   state_t         : table-walker FSM states
//   tx_cmd_t        : operations requested from sccb_byte_tx
//   sccb_entry_t    : one table entry, {addr, data}
//   sccb_init_table : returns the entry at a table index. table_sel picks an
//                     alternate table; 0 is the production camera setup.
package sccb_init_pkg;

    typedef enum logic [3:0] {
        IDLE, LOAD, START, PHASE, STOP, GAP, NEXT, DELAY, DONE
    } state_t;

    typedef enum logic [1:0] {
        CMD_START, CMD_BYTE, CMD_STOP
    } tx_cmd_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sccb_entry_t;

    localparam logic [7:0] SCCB_END_ADDR   = 8'hFF;
    localparam logic [7:0] SCCB_DELAY_ADDR = 8'hFE;

    function automatic sccb_entry_t sccb_init_table(input int unsigned index,
                                                    input int unsigned table_sel = 0);
        sccb_entry_t e;
        e = '{addr: SCCB_END_ADDR, data: 8'hFF};
        case (table_sel)
            0: case (index)
                   0: e = '{8'h12, 8'h80};   // COM7: soft reset
                   1: e = '{8'hFE, 8'h0A};   // settle after reset
                   2: e = '{8'h11, 8'h01};   // CLKRC
                   3: e = '{8'h12, 8'h04};   // COM7: RGB output
                   4: e = '{8'h0C, 8'h04};   // COM3
                   5: e = '{8'h3E, 8'h19};   // COM14
                   6: e = '{8'h40, 8'hD0};   // COM15: RGB565
                   default: ;
               endcase
            1: case (index)
                   0: e = '{8'h12, 8'h80};
                   1: e = '{8'h11, 8'h01};
                   default: ;
               endcase
            2: ;                              // empty table
            3: e = '{addr: 8'(index), data: 8'(index * 7 + 3)};  // full table, no END
            4: if (index == 0) e = '{8'hFE, 8'h02};
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sccb_byte_tx.sv
// SCCB bit engine: quarter-period tick divider plus START / 9-bit byte / STOP
// sequencing. Single-cycle go strobe in, single-cycle ack strobe out.
//   div_run, div_clr : divider enable and restart
//   tick             : quarter-SCCB-period strobe (also used for GAP timing)
//   go, cmd, tx_data : operation request
//   ack              : operation finished
//   sio_c, sio_d_oe  : bus pins (sio_d_oe=1 pulls SIO_D low)
module sccb_byte_tx
    import sccb_init_pkg::*;
#(
    parameter int TICK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       div_run,
    input  logic       div_clr,
    output logic       tick,
    input  logic       go,
    input  tx_cmd_t    cmd,
    input  logic [7:0] tx_data,
    output logic       ack,
    output logic       sio_c,
    output logic       sio_d_oe
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div;
    logic             active;
    tx_cmd_t          op;
    logic [1:0]       qtr;      // quarter within the current 4-tick slot
    logic [3:0]       bit_cnt;  // 0..8, bit 8 is the released ACK slot
    logic [7:0]       shift;

    assign tick = div_run && !div_clr && (div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || div_clr || !div_run || tick)
            div <= '0;
        else
            div <= div + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            active   <= 1'b0;
            op       <= CMD_START;
            qtr      <= 2'd0;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            ack      <= 1'b0;
            sio_c    <= 1'b1;
            sio_d_oe <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (!active) begin
                if (go) begin
                    active  <= 1'b1;
                    op      <= cmd;
                    shift   <= tx_data;
                    qtr     <= 2'd0;
                    bit_cnt <= 4'd0;
                end
            end else if (tick) begin
                qtr <= qtr + 2'd1;
                case (op)
                    CMD_START: begin
                        // SIO_D falls while SIO_C is high, then SIO_C drops.
                        if (qtr == 2'd0) sio_d_oe <= 1'b1;
                        if (qtr == 2'd2) sio_c    <= 1'b0;
                    end
                    CMD_BYTE: begin
                        case (qtr)
                            2'd0: sio_d_oe <= (bit_cnt == 4'd8) ? 1'b0 : ~shift[7];
                            2'd1: sio_c    <= 1'b1;
                            2'd3: begin
                                sio_c   <= 1'b0;
                                bit_cnt <= bit_cnt + 4'd1;
                                shift   <= {shift[6:0], 1'b0};
                            end
                            default: ;
                        endcase
                    end
                    CMD_STOP: begin
                        // SIO_D rises while SIO_C is high.
                        if (qtr == 2'd0) sio_d_oe <= 1'b1;
                        if (qtr == 2'd1) sio_c    <= 1'b1;
                        if (qtr == 2'd2) sio_d_oe <= 1'b0;
                    end
                    default: ;
                endcase
                if (qtr == 2'd3 && (op != CMD_BYTE || bit_cnt == 4'd8)) begin
                    active <= 1'b0;
                    ack    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal.
//   clk, reset_n : clock, synchronous active-low reset
//   d            : asynchronous input
//   q            : synchronized output, two clocks of latency
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: sequential state is written with non-blocking assignments so each
    // flop samples the value its neighbour held before the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sccb_init_engine.sv
// SCCB init engine: on a kick, writes every table entry to the camera as a
// 3-phase write (SLAVE_ID, addr, data), then holds sccb_done until the kick
// is withdrawn.
//   clk, reset_n        : clock, synchronous active-low reset
//   sccb_kick           : start request level (asynchronous, synchronized here)
//   sccb_done           : table complete, held until kick drops
//   sio_c               : SCCB clock
//   sio_d_out, sio_d_oe : SIO_D value (always 0) and pull-low enable
//   busy                : run in progress
// Build option: define SCCB_INIT_DELAY_EN to treat addr 8'hFE as a
// millisecond delay pseudo-command instead of a register write.
module sccb_init_engine
    import sccb_init_pkg::*;
#(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          SCCB_HZ     = 100_000,
    parameter logic [7:0]  SLAVE_ID    = 8'h42,
    parameter int          TABLE_DEPTH = 64,
    parameter int          MS_CYCLES   = CLK_HZ / 1000,
    parameter int unsigned TABLE_SEL   = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sccb_kick,
    output logic sccb_done,
    output logic sio_c,
    output logic sio_d_out,
    output logic sio_d_oe,
    output logic busy
);
`ifdef SCCB_INIT_DELAY_EN
    localparam bit DELAY_EN = 1'b1;
`else
    localparam bit DELAY_EN = 1'b0;
`endif
    localparam int IDX_W = $clog2(TABLE_DEPTH);

    state_t            state;
    logic [IDX_W-1:0]  index;
    logic [1:0]        byte_sel;
    logic [1:0]        gap_cnt;
    logic [31:0]       delay_cnt;
    logic              kick_sync;
    logic              go;
    tx_cmd_t           cmd;
    logic [7:0]        tx_data;
    logic              tx_ack;
    logic              tick;
    sccb_entry_t       cur_entry;

    assign sio_d_out = 1'b0;
    assign cur_entry = sccb_init_table(32'(index), TABLE_SEL);

    sync_2ff u_kick_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (sccb_kick),
        .q       (kick_sync)
    );

    sccb_byte_tx #(
        .TICK_DIV (CLK_HZ / (4 * SCCB_HZ))
    ) u_byte_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .div_run  ((state != IDLE) && (state != DONE)),
        .div_clr  (state == LOAD),
        .tick     (tick),
        .go       (go),
        .cmd      (cmd),
        .tx_data  (tx_data),
        .ack      (tx_ack),
        .sio_c    (sio_c),
        .sio_d_oe (sio_d_oe)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            index     <= '0;
            byte_sel  <= 2'd0;
            gap_cnt   <= 2'd0;
            delay_cnt <= 32'd0;
            go        <= 1'b0;
            cmd       <= CMD_START;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
            sccb_done <= 1'b0;
        end else begin
            go <= 1'b0;  // go is a one-cycle strobe
            case (state)
                IDLE: if (kick_sync && !sccb_done) begin
                    index <= '0;
                    state <= LOAD;
                end
                LOAD: begin
                    if (cur_entry.addr == SCCB_END_ADDR) begin
                        busy      <= 1'b0;
                        sccb_done <= 1'b1;
                        state     <= DONE;
                    end else if (DELAY_EN && cur_entry.addr == SCCB_DELAY_ADDR) begin
                        busy      <= 1'b1;
                        delay_cnt <= 32'(cur_entry.data) * 32'(MS_CYCLES);
                        state     <= DELAY;
                    end else begin
                        busy  <= 1'b1;
                        go    <= 1'b1;
                        cmd   <= CMD_START;
                        state <= START;
                    end
                end
                START: if (tx_ack) begin
                    go       <= 1'b1;
                    cmd      <= CMD_BYTE;
                    tx_data  <= SLAVE_ID;
                    byte_sel <= 2'd0;
                    state    <= PHASE;
                end
                PHASE: if (tx_ack) begin
                    go <= 1'b1;
                    if (byte_sel == 2'd2) begin
                        cmd   <= CMD_STOP;
                        state <= STOP;
                    end else begin
                        cmd      <= CMD_BYTE;
                        tx_data  <= (byte_sel == 2'd0) ? cur_entry.addr : cur_entry.data;
                        byte_sel <= byte_sel + 2'd1;
                    end
                end
                STOP: if (tx_ack) begin
                    gap_cnt <= 2'd0;
                    state   <= GAP;
                end
                GAP: if (tick) begin
                    if (gap_cnt == 2'd3) state <= NEXT;
                    else                 gap_cnt <= gap_cnt + 2'd1;
                end
                DELAY: begin
                    if (delay_cnt == 32'd0) state <= NEXT;
                    else                    delay_cnt <= delay_cnt - 32'd1;
                end
                NEXT: begin
                    // The last slot ends the run even without an END entry.
                    if (index == IDX_W'(TABLE_DEPTH - 1)) begin
                        busy      <= 1'b0;
                        sccb_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        index <= index + 1'b1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    if (!kick_sync) begin
                        sccb_done <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sccb_init_engine.md
# sccb_init_engine

Responder for the sequencer's SCCB kick/done handshake. When `sccb_kick` is raised, the block walks a fixed register table and writes each entry to the camera over SCCB using 3-phase write transactions (slave ID, register address, data). It then raises `sccb_done` and holds it until the kick is withdrawn. It sits between the main sequencer and the camera's SIO_C/SIO_D pins.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency.
- `SCCB_HZ`, 100_000, SIO_C frequency.
- `SLAVE_ID`, 8'h42, write ID sent in phase 1.
- `TABLE_DEPTH`, 64, maximum number of table entries. Index width is clog2(TABLE_DEPTH).
- `MS_CYCLES`, CLK_HZ/1000, clock cycles per millisecond for delay entries.

- `clk` in 1: system clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `sccb_kick` in 1: start request, level. Passed through an internal 2-flop synchronizer.
- `sccb_done` out 1: table complete, held until the kick drops.
- `sio_c` out 1: SCCB clock, push-pull.
- `sio_d_out` out 1: SCCB data value. Always 0 (open-drain style).
- `sio_d_oe` out 1: 1 = drive SIO_D low, 0 = release it (pulled high).
- `busy` out 1: high from LOAD through STOP/GAP/DELAY, for LED use.

## Operation
- Reset values: `sio_c`=1, `sio_d_oe`=0, `sio_d_out`=0, `sccb_done`=0, `busy`=0. State is IDLE, table index is 0, divider is 0.
- Table entry format: 16 bits, {addr[15:8], data[7:0]}.
  - addr 8'hFF is END.
  - A run also ends after entry TABLE_DEPTH-1.
- States:
  - IDLE: on kick_sync=1 and done=0, go to LOAD with index 0.
  - LOAD: fetch the entry.
    - END: go to DONE.
    - Delay entry (macro enabled): go to DELAY.
    - Otherwise: go to START.
  - START: go to PHASE.
  - PHASE: 3 bytes × 9 bits each.
    - Bits 0-7 are sent MSB first. A 0 bit drives `sio_d_oe`=1; a 1 bit drives `sio_d_oe`=0.
    - Bit 8 is don't-care: SIO_D is released and the ACK is not checked.
  - STOP: go to GAP.
  - GAP: 4 idle ticks, then NEXT.
  - NEXT: increment the index, then LOAD.
  - DONE: `sccb_done`=1. Leave when kick_sync=0: `sccb_done`=0 on the next edge, then IDLE.
- A kick that falls mid-run is ignored. The run completes; DONE then lasts exactly 1 cycle and returns to IDLE.
- A kick held high after done produces no rerun. A new run requires kick low, then high again.
- Reset asserted mid-transaction: all outputs take their reset values on that edge and the bus is released immediately. The slave may see a truncated transfer; the next kick restarts from entry 0.

## Timing
- Tick: quarter SCCB period, every CLK_HZ/(4*SCCB_HZ) cycles (125 at defaults). The divider runs only outside IDLE and DONE, and restarts at 0 in LOAD.
- Each bit takes 4 ticks: set SIO_D with `sio_c`=0, raise `sio_c`, hold, lower `sio_c`.
- START, entered with `sio_c`=1:
  - tick 0: SIO_D driven low while `sio_c` is high.
  - tick 2: `sio_c` goes low.
- STOP:
  - SIO_D low, `sio_c` low.
  - `sio_c` high.
  - After 1 tick, SIO_D released.
- Per-transaction length: 4 (START) + 108 (PHASE) + 4 (STOP) + 4 (GAP) = 120 ticks.
- Latency:
  - kick sampled high at edge N: `busy`=1 after edge N+3.
  - END entry: `sccb_done`=1 two cycles after LOAD.
  - kick low at edge M: `sccb_done`=0 after edge M+3.

## Configuration
- `SCCB_INIT_DELAY_EN`:
  - Defined: an entry with addr 8'hFE is a pseudo-command. It waits data × MS_CYCLES cycles with the bus idle (`sio_c`=1, `sio_d_oe`=0), then goes to NEXT. data=0 waits 0 cycles.
  - Undefined: 8'hFE is written to the camera as an ordinary register.

## Structure
- Package `sccb_init_pkg` holds:
  - state enum: IDLE, LOAD, START, PHASE, STOP, GAP, NEXT, DELAY, DONE;
  - entry typedef;
  - constants `SCCB_END_ADDR`=8'hFF and `SCCB_DELAY_ADDR`=8'hFE;
  - the table function `sccb_init_table(index)` returning an entry.
- The synchronizer reuses the existing 2-flop sync cell.
- One sub-module, `sccb_byte_tx`, owns the divider and the START/byte/STOP bit sequencing. It uses a go/ack handshake with the table FSM.

## Test plan
- Bench setting: CLK_HZ=400, SCCB_HZ=100 (1-cycle ticks), with a bus monitor.
- Table {12,80},{11,01},{FF,FF}; kick high → monitor decodes 42 12 80, then 42 11 01 → `sccb_done`=1. Kick low → `sccb_done`=0 within 3 cycles.
- First entry {FF,FF} → no `sio_c` edges → `sccb_done`=1 within 6 cycles of kick.
- `reset_n`=0 during byte 2 bit 3 → next edge `sio_c`=1, `sio_d_oe`=0, `busy`=0, `sccb_done`=0. A fresh kick replays entry 0.
- Entry {FE,02} with MS_CYCLES=10:
  - Macro on: bus idle for 20 cycles, no transaction.
  - Macro off: monitor decodes 42 FE 02.
- 64 entries with no END → exactly 64 transactions → done. Kick held high → no rerun. Kick low then high → 64 more transactions.
